// File: rtl/nested_ifs_cfg_loader_pkg.sv
// Shared types, word indices and ctrl-word bit positions for the configuration loader.
// NESTED_IFS_CFG_CHECKSUM_EN (in the top) adds a trailing XOR checksum word to every frame.
package nested_ifs_cfg_loader_pkg;

  typedef logic [31:0] int32_t;
  typedef logic [1:0]  int2_t;
  typedef logic        bool;

  localparam int unsigned NumCons   = 11;
  localparam int unsigned Ctrl0Bits = 29;
  localparam int unsigned Ctrl1Bits = 10;

  localparam logic [3:0] IdxCtrl0 = 4'd11;
  localparam logic [3:0] IdxCtrl1 = 4'd12;

  // ctrl0 field positions
  localparam int unsigned C0Sel1  = 0;
  localparam int unsigned C0Sel8  = 7;
  localparam int unsigned C0Sel9  = 9;
  localparam int unsigned C0Sel10 = 11;
  localparam int unsigned C0Sel11 = 12;
  localparam int unsigned C0Sel12 = 14;
  localparam int unsigned C0Sel13 = 16;
  localparam int unsigned C0Sel17 = 20;
  localparam int unsigned C0Sel18 = 22;
  localparam int unsigned C0Sel19 = 24;
  localparam int unsigned C0Sel20 = 25;
  localparam int unsigned C0Sel21 = 27;

  // ctrl1 field positions
  localparam int unsigned C1Rel1   = 0;
  localparam int unsigned C1Rel2   = 2;
  localparam int unsigned C1Rel3   = 4;
  localparam int unsigned C1Arith1 = 6;

  typedef enum logic [1:0] {StIdle, StLoad, StCheck, StCommit} state_e;

  // Reserved ctrl bits are never stored.
  typedef struct packed {
    int32_t [NumCons-1:0]  cons;
    logic [Ctrl0Bits-1:0]  ctrl0;
    logic [Ctrl1Bits-1:0]  ctrl1;
  } cfg_t;

  typedef struct packed {
    logic [6:0] sel_1_7;
    int2_t      sel_8;
    int2_t      sel_9;
    bool        sel_10;
    int2_t      sel_11;
    int2_t      sel_12;
    logic [3:0] sel_13_16;
    int2_t      sel_17;
    int2_t      sel_18;
    bool        sel_19;
    int2_t      sel_20;
    int2_t      sel_21;
    int2_t      rel_op1;
    int2_t      rel_op2;
    int2_t      rel_op3;
    logic [3:0] arith_op;
  } fields_t;

endpackage

// File: rtl/nested_ifs_cfg_unpack.sv
// Combinational decoder from the stored ctrl0/ctrl1 words to select and opcode fields.
module nested_ifs_cfg_unpack
  import nested_ifs_cfg_loader_pkg::*;
(
  input  logic [Ctrl0Bits-1:0] ctrl0_i,
  input  logic [Ctrl1Bits-1:0] ctrl1_i,
  output fields_t              fields_o
);

  always_comb begin
    fields_o           = '0;
    fields_o.sel_1_7   = ctrl0_i[C0Sel1 +: 7];
    fields_o.sel_8     = ctrl0_i[C0Sel8 +: 2];
    fields_o.sel_9     = ctrl0_i[C0Sel9 +: 2];
    fields_o.sel_10    = ctrl0_i[C0Sel10];
    fields_o.sel_11    = ctrl0_i[C0Sel11 +: 2];
    fields_o.sel_12    = ctrl0_i[C0Sel12 +: 2];
    fields_o.sel_13_16 = ctrl0_i[C0Sel13 +: 4];
    fields_o.sel_17    = ctrl0_i[C0Sel17 +: 2];
    fields_o.sel_18    = ctrl0_i[C0Sel18 +: 2];
    fields_o.sel_19    = ctrl0_i[C0Sel19];
    fields_o.sel_20    = ctrl0_i[C0Sel20 +: 2];
    fields_o.sel_21    = ctrl0_i[C0Sel21 +: 2];
    fields_o.rel_op1   = ctrl1_i[C1Rel1 +: 2];
    fields_o.rel_op2   = ctrl1_i[C1Rel2 +: 2];
    fields_o.rel_op3   = ctrl1_i[C1Rel3 +: 2];
    fields_o.arith_op  = ctrl1_i[C1Arith1 +: 4];
  end

endmodule

// File: rtl/nested_ifs_cfg_loader.sv
// Frame-based configuration loader: words land in a shadow copy and reach the outputs on commit.
// Define NESTED_IFS_CFG_CHECKSUM_EN to require a trailing XOR checksum word before commit.
module nested_ifs_cfg_loader
  import nested_ifs_cfg_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i__cfg_start,
  input  logic [31:0] i__cfg_data,
  input  logic        i__cfg_valid,
  output logic        o__cfg_ready,
  output logic [31:0] o__cons_1,
  output logic [31:0] o__cons_2,
  output logic [31:0] o__cons_3,
  output logic [31:0] o__cons_4,
  output logic [31:0] o__cons_5,
  output logic [31:0] o__cons_6,
  output logic [31:0] o__cons_7,
  output logic [31:0] o__cons_8,
  output logic [31:0] o__cons_9,
  output logic [31:0] o__cons_10,
  output logic [31:0] o__cons_11,
  output logic        o__sel_1,
  output logic        o__sel_2,
  output logic        o__sel_3,
  output logic        o__sel_4,
  output logic        o__sel_5,
  output logic        o__sel_6,
  output logic        o__sel_7,
  output logic [1:0]  o__sel_8,
  output logic [1:0]  o__sel_9,
  output logic        o__sel_10,
  output logic [1:0]  o__sel_11,
  output logic [1:0]  o__sel_12,
  output logic        o__sel_13,
  output logic        o__sel_14,
  output logic        o__sel_15,
  output logic        o__sel_16,
  output logic [1:0]  o__sel_17,
  output logic [1:0]  o__sel_18,
  output logic        o__sel_19,
  output logic [1:0]  o__sel_20,
  output logic [1:0]  o__sel_21,
  output logic [1:0]  o__rel_op1,
  output logic [1:0]  o__rel_op2,
  output logic [1:0]  o__rel_op3,
  output logic        o__arith_op1,
  output logic        o__arith_op2,
  output logic        o__arith_op3,
  output logic        o__arith_op4,
  output logic        o__cfg_busy,
  output logic        o__cfg_done,
  output logic        o__cfg_err
);

  state_e     state_q;
  logic [3:0] idx_q;
  cfg_t       shadow_q, active_q, commit_cfg;
  logic       done_q, err_q;
`ifdef NESTED_IFS_CFG_CHECKSUM_EN
  int32_t     csum_q;
`endif
  fields_t    fields;

  // Shadow as it stands once the ctrl1 word currently on the bus is included.
  always_comb begin
    commit_cfg       = shadow_q;
    commit_cfg.ctrl1 = i__cfg_data[Ctrl1Bits-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef NESTED_IFS_CFG_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i__cfg_start) begin
            state_q <= StLoad;
            idx_q   <= '0;
`ifdef NESTED_IFS_CFG_CHECKSUM_EN
            csum_q  <= '0;
`endif
          end
        end
        StLoad: begin
          if (i__cfg_start) begin
            err_q <= 1'b1;
            idx_q <= '0;
`ifdef NESTED_IFS_CFG_CHECKSUM_EN
            csum_q <= '0;
`endif
          end else if (i__cfg_valid) begin
`ifdef NESTED_IFS_CFG_CHECKSUM_EN
            csum_q <= csum_q ^ i__cfg_data;
`endif
            if (idx_q == IdxCtrl1) begin
              shadow_q.ctrl1 <= i__cfg_data[Ctrl1Bits-1:0];
`ifdef NESTED_IFS_CFG_CHECKSUM_EN
              state_q  <= StCheck;
`else
              // Active updates on entry so outputs change together with done.
              active_q <= commit_cfg;
              done_q   <= 1'b1;
              state_q  <= StCommit;
`endif
            end else begin
              if (idx_q == IdxCtrl0) begin
                shadow_q.ctrl0 <= i__cfg_data[Ctrl0Bits-1:0];
              end else begin
                shadow_q.cons[idx_q] <= i__cfg_data;
              end
              idx_q <= idx_q + 4'd1;
            end
          end
        end
`ifdef NESTED_IFS_CFG_CHECKSUM_EN
        StCheck: begin
          if (i__cfg_start) begin
            err_q   <= 1'b1;
            idx_q   <= '0;
            csum_q  <= '0;
            state_q <= StLoad;
          end else if (i__cfg_valid) begin
            if (i__cfg_data == csum_q) begin
              active_q <= shadow_q;
              done_q   <= 1'b1;
              state_q  <= StCommit;
            end else begin
              err_q   <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
`endif
        StCommit: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  nested_ifs_cfg_unpack u_unpack (
    .ctrl0_i  (active_q.ctrl0),
    .ctrl1_i  (active_q.ctrl1),
    .fields_o (fields)
  );

  assign o__cfg_ready = (state_q == StLoad) || (state_q == StCheck);
  assign o__cfg_busy  = (state_q != StIdle);
  assign o__cfg_done  = done_q;
  assign o__cfg_err   = err_q;

  assign o__cons_1  = active_q.cons[0];
  assign o__cons_2  = active_q.cons[1];
  assign o__cons_3  = active_q.cons[2];
  assign o__cons_4  = active_q.cons[3];
  assign o__cons_5  = active_q.cons[4];
  assign o__cons_6  = active_q.cons[5];
  assign o__cons_7  = active_q.cons[6];
  assign o__cons_8  = active_q.cons[7];
  assign o__cons_9  = active_q.cons[8];
  assign o__cons_10 = active_q.cons[9];
  assign o__cons_11 = active_q.cons[10];

  assign {o__sel_7, o__sel_6, o__sel_5, o__sel_4, o__sel_3, o__sel_2, o__sel_1} = fields.sel_1_7;
  assign o__sel_8  = fields.sel_8;
  assign o__sel_9  = fields.sel_9;
  assign o__sel_10 = fields.sel_10;
  assign o__sel_11 = fields.sel_11;
  assign o__sel_12 = fields.sel_12;
  assign {o__sel_16, o__sel_15, o__sel_14, o__sel_13} = fields.sel_13_16;
  assign o__sel_17 = fields.sel_17;
  assign o__sel_18 = fields.sel_18;
  assign o__sel_19 = fields.sel_19;
  assign o__sel_20 = fields.sel_20;
  assign o__sel_21 = fields.sel_21;

  assign o__rel_op1 = fields.rel_op1;
  assign o__rel_op2 = fields.rel_op2;
  assign o__rel_op3 = fields.rel_op3;
  assign {o__arith_op4, o__arith_op3, o__arith_op2, o__arith_op1} = fields.arith_op;

endmodule

// File: tb/tb_nested_ifs_cfg_loader.sv
// Directed bench with a frame-level model (word list + committed word array) checked every cycle.
module tb_nested_ifs_cfg_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i__cfg_start = 1'b0;
  logic [31:0] i__cfg_data = '0;
  logic        i__cfg_valid = 1'b0;
  logic        o__cfg_ready, o__cfg_busy, o__cfg_done, o__cfg_err;
  logic [31:0] o__cons_1, o__cons_2, o__cons_3, o__cons_4, o__cons_5, o__cons_6;
  logic [31:0] o__cons_7, o__cons_8, o__cons_9, o__cons_10, o__cons_11;
  logic        o__sel_1, o__sel_2, o__sel_3, o__sel_4, o__sel_5, o__sel_6, o__sel_7;
  logic        o__sel_10, o__sel_13, o__sel_14, o__sel_15, o__sel_16, o__sel_19;
  logic [1:0]  o__sel_8, o__sel_9, o__sel_11, o__sel_12, o__sel_17, o__sel_18;
  logic [1:0]  o__sel_20, o__sel_21;
  logic [1:0]  o__rel_op1, o__rel_op2, o__rel_op3;
  logic        o__arith_op1, o__arith_op2, o__arith_op3, o__arith_op4;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  nested_ifs_cfg_loader dut (
    .clk(clk), .rst(rst), .i__cfg_start(i__cfg_start), .i__cfg_data(i__cfg_data),
    .i__cfg_valid(i__cfg_valid), .o__cfg_ready(o__cfg_ready),
    .o__cons_1(o__cons_1), .o__cons_2(o__cons_2), .o__cons_3(o__cons_3),
    .o__cons_4(o__cons_4), .o__cons_5(o__cons_5), .o__cons_6(o__cons_6),
    .o__cons_7(o__cons_7), .o__cons_8(o__cons_8), .o__cons_9(o__cons_9),
    .o__cons_10(o__cons_10), .o__cons_11(o__cons_11),
    .o__sel_1(o__sel_1), .o__sel_2(o__sel_2), .o__sel_3(o__sel_3), .o__sel_4(o__sel_4),
    .o__sel_5(o__sel_5), .o__sel_6(o__sel_6), .o__sel_7(o__sel_7), .o__sel_8(o__sel_8),
    .o__sel_9(o__sel_9), .o__sel_10(o__sel_10), .o__sel_11(o__sel_11),
    .o__sel_12(o__sel_12), .o__sel_13(o__sel_13), .o__sel_14(o__sel_14),
    .o__sel_15(o__sel_15), .o__sel_16(o__sel_16), .o__sel_17(o__sel_17),
    .o__sel_18(o__sel_18), .o__sel_19(o__sel_19), .o__sel_20(o__sel_20),
    .o__sel_21(o__sel_21),
    .o__rel_op1(o__rel_op1), .o__rel_op2(o__rel_op2), .o__rel_op3(o__rel_op3),
    .o__arith_op1(o__arith_op1), .o__arith_op2(o__arith_op2),
    .o__arith_op3(o__arith_op3), .o__arith_op4(o__arith_op4),
    .o__cfg_busy(o__cfg_busy), .o__cfg_done(o__cfg_done), .o__cfg_err(o__cfg_err)
  );

`ifdef NESTED_IFS_CFG_CHECKSUM_EN
  localparam int FrameWords = 14;
`else
  localparam int FrameWords = 13;
`endif

  // ---------------- frame-level model ----------------
  bit          m_in_frame = 1'b0;
  bit          m_commit_cyc = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_words[$];
  logic [31:0] m_act[13];

  initial foreach (m_act[k]) m_act[k] = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_in_frame = 0; m_commit_cyc = 0; m_done = 0; m_err = 0;
      m_words.delete();
      foreach (m_act[k]) m_act[k] = '0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (m_commit_cyc) begin
        m_commit_cyc = 0;
      end else if (!m_in_frame) begin
        if (i__cfg_start) begin
          m_in_frame = 1;
          m_words.delete();
        end
      end else if (i__cfg_start) begin
        m_err = 1;
        m_words.delete();
      end else if (i__cfg_valid) begin
        m_words.push_back(i__cfg_data);
        if (m_words.size() == FrameWords) begin
          logic [31:0] x;
          x = '0;
          for (int k = 0; k < 13; k++) x ^= m_words[k];
          m_in_frame = 0;
          if (FrameWords == 13 || x == m_words[13]) begin
            for (int k = 0; k < 13; k++) m_act[k] = m_words[k];
            m_done = 1;
            m_commit_cyc = 1;
          end else begin
            m_err = 1;
          end
        end
      end
    end
  end

  function automatic int sel_w(int n);
    return (n inside {8, 9, 11, 12, 17, 18, 20, 21}) ? 2 : 1;
  endfunction

  // Field of select n, found by summing widths of the selects below it.
  function automatic logic [31:0] exp_sel(int n, logic [31:0] c0);
    int pos = 0;
    for (int k = 1; k < n; k++) pos += sel_w(k);
    return (c0 >> pos) & ((32'd1 << sel_w(n)) - 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] dcons[11];
  logic [1:0]  dsel[1:21];
  logic [1:0]  drel[3];
  logic        dar[4];

  always @(negedge clk) begin
    if (chk_en) begin
      dcons = '{o__cons_1, o__cons_2, o__cons_3, o__cons_4, o__cons_5, o__cons_6,
                o__cons_7, o__cons_8, o__cons_9, o__cons_10, o__cons_11};
      dsel = '{{1'b0, o__sel_1}, {1'b0, o__sel_2}, {1'b0, o__sel_3}, {1'b0, o__sel_4},
               {1'b0, o__sel_5}, {1'b0, o__sel_6}, {1'b0, o__sel_7}, o__sel_8, o__sel_9,
               {1'b0, o__sel_10}, o__sel_11, o__sel_12, {1'b0, o__sel_13},
               {1'b0, o__sel_14}, {1'b0, o__sel_15}, {1'b0, o__sel_16}, o__sel_17,
               o__sel_18, {1'b0, o__sel_19}, o__sel_20, o__sel_21};
      drel = '{o__rel_op1, o__rel_op2, o__rel_op3};
      dar  = '{o__arith_op1, o__arith_op2, o__arith_op3, o__arith_op4};
      chk("ready", {31'd0, o__cfg_ready}, {31'd0, m_in_frame});
      chk("busy", {31'd0, o__cfg_busy}, {31'd0, m_in_frame | m_commit_cyc});
      chk("done", {31'd0, o__cfg_done}, {31'd0, m_done});
      chk("err", {31'd0, o__cfg_err}, {31'd0, m_err});
      for (int k = 0; k < 11; k++) chk($sformatf("cons_%0d", k + 1), dcons[k], m_act[k]);
      for (int n = 1; n <= 21; n++)
        chk($sformatf("sel_%0d", n), {30'd0, dsel[n]}, exp_sel(n, m_act[11]));
      for (int k = 0; k < 3; k++)
        chk($sformatf("rel_op%0d", k + 1), {30'd0, drel[k]}, (m_act[12] >> (2 * k)) & 3);
      for (int k = 0; k < 4; k++)
        chk($sformatf("arith_op%0d", k + 1), {31'd0, dar[k]}, (m_act[12] >> (6 + k)) & 1);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] frame[13];

  task automatic drive(bit s, bit v, logic [31:0] d, bit r = 1'b0);
    rst = r; i__cfg_start = s; i__cfg_valid = v; i__cfg_data = d;
    @(posedge clk);
    #1;
  endtask

  // Words first..12 (plus checksum when built in); last handshake completes on return.
  task automatic send_words(int first, bit gaps, bit bad_sum = 1'b0);
    logic [31:0] x;
    x = '0;
    for (int k = 0; k < 13; k++) x ^= frame[k];
    for (int k = first; k < 13; k++) begin
      if (gaps) drive(1'b0, 1'b0, 32'hDEAD_BEEF);
      drive(1'b0, 1'b1, frame[k]);
    end
`ifdef NESTED_IFS_CFG_CHECKSUM_EN
    drive(1'b0, 1'b1, bad_sum ? (x ^ 32'd1) : x);
`else
    if (bad_sum) x = '0;
`endif
    i__cfg_valid = 1'b0;
  endtask

  task automatic set_frame(logic [31:0] base, logic [31:0] c0, logic [31:0] c1);
    for (int k = 0; k < 11; k++) frame[k] = base + k + 1;
    frame[11] = c0;
    frame[12] = c1;
  endtask

  initial begin
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);
    chk_en = 1'b1;
    chk("reset cons_1", o__cons_1, 32'd0);
    chk("reset sel_8", {30'd0, o__sel_8}, 32'd0);
    chk("reset busy", {31'd0, o__cfg_busy}, 32'd0);
    drive(1'b0, 1'b0, '0);

    // Full frame, valid every cycle.
    set_frame(32'd0, 32'h1FFF_FFFF, 32'h0000_03FF);
    drive(1'b1, 1'b0, '0);
    send_words(0, 1'b0);
    chk("frame1 done", {31'd0, o__cfg_done}, 32'd1);
    chk("frame1 cons_5", o__cons_5, 32'd5);
    chk("frame1 sel_1", {31'd0, o__sel_1}, 32'd1);
    chk("frame1 sel_21", {30'd0, o__sel_21}, 32'd3);
    chk("frame1 rel_op2", {30'd0, o__rel_op2}, 32'd3);
    chk("frame1 arith_op4", {31'd0, o__arith_op4}, 32'd1);
    drive(1'b0, 1'b0, '0);
    chk("frame1 done pulse", {31'd0, o__cfg_done}, 32'd0);
    drive(1'b0, 1'b0, '0);

    // Same frame with valid gaps.
    drive(1'b1, 1'b0, '0);
    send_words(0, 1'b1);
    chk("gaps done", {31'd0, o__cfg_done}, 32'd1);
    chk("gaps cons_11", o__cons_11, 32'd11);
    drive(1'b0, 1'b0, '0);

    // Abort after word 6 of a 0xAA frame; the start cycle also carries a discarded word.
    for (int k = 0; k < 13; k++) frame[k] = 32'hAA;
    drive(1'b1, 1'b0, '0);
    for (int k = 0; k <= 6; k++) drive(1'b0, 1'b1, frame[k]);
    drive(1'b1, 1'b1, 32'hAA);
    chk("abort err", {31'd0, o__cfg_err}, 32'd1);
    chk("abort cons_1", o__cons_1, 32'd1);
    set_frame(32'h10, 32'h0000_0155, 32'h0000_0021);
    send_words(0, 1'b0);
    chk("restart cons_1", o__cons_1, 32'h11);
    chk("restart sel_1", {31'd0, o__sel_1}, 32'd1);
    drive(1'b0, 1'b0, '0);

    // Reserved ctrl bits set.
    set_frame(32'h100, 32'hF234_5678, 32'hFFFF_FEC5);
    drive(1'b1, 1'b0, '0);
    send_words(0, 1'b0);
    chk("resv sel_9", {30'd0, o__sel_9}, 32'd3);
    chk("resv sel_4", {31'd0, o__sel_4}, 32'd1);
    chk("resv rel_op1", {30'd0, o__rel_op1}, 32'd1);
    chk("resv arith_op3", {31'd0, o__arith_op3}, 32'd0);
    chk("resv arith_op4", {31'd0, o__arith_op4}, 32'd1);
    drive(1'b0, 1'b0, '0);

`ifdef NESTED_IFS_CFG_CHECKSUM_EN
    // Bad checksum: error, actives keep the reserved-bits frame.
    set_frame(32'h200, 32'h0, 32'h0);
    drive(1'b1, 1'b0, '0);
    send_words(0, 1'b0, 1'b1);
    chk("badsum err", {31'd0, o__cfg_err}, 32'd1);
    chk("badsum cons_1", o__cons_1, 32'h101);
    drive(1'b0, 1'b0, '0);
`endif

    // Reset while word 9 is on the bus.
    set_frame(32'h300, 32'h1FFF_FFFF, 32'h3FF);
    drive(1'b1, 1'b0, '0);
    for (int k = 0; k <= 8; k++) drive(1'b0, 1'b1, frame[k]);
    drive(1'b0, 1'b1, frame[9], 1'b1);
    chk("rst cons_1", o__cons_1, 32'd0);
    chk("rst done", {31'd0, o__cfg_done}, 32'd0);
    chk("rst ready", {31'd0, o__cfg_ready}, 32'd0);
    drive(1'b0, 1'b1, frame[10]);
    drive(1'b0, 1'b1, frame[11]);
    drive(1'b0, 1'b1, frame[12]);
    chk("rst no commit", {31'd0, o__cfg_done}, 32'd0);
    drive(1'b0, 1'b0, '0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nested_ifs_cfg_loader.md
NESTED_IFS_CFG_LOADER -- requirements
Module: nested_ifs_cfg_loader

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port i__cfg_start, input, 1 bit: pulse that opens a new configuration frame.
REQ-004 SHALL have port i__cfg_data, input, 32 bits: configuration word.
REQ-005 SHALL have port i__cfg_valid, input, 1 bit: i__cfg_data is valid.
REQ-006 SHALL have port o__cfg_ready, output, 1 bit: the loader accepts a word.
REQ-007 SHALL have ports o__cons_1..o__cons_11, output, 32 bits each: active constants for the downstream atom.
REQ-008 SHALL have ports o__sel_1..o__sel_21, output, 2 bits for sel 8, 9, 11, 12, 17, 18, 20 and 21, otherwise 1 bit: active mux selects.
REQ-009 SHALL have ports o__rel_op1..o__rel_op3 (2 bits each) and o__arith_op1..o__arith_op4 (1 bit each), output: active opcodes.
REQ-010 SHALL have ports o__cfg_busy, o__cfg_done and o__cfg_err, output, 1 bit each: frame in progress, commit pulse, and abort/error pulse.

Function
REQ-011 SHALL transfer a word only on a cycle where i__cfg_valid and o__cfg_ready are both 1.
REQ-012 SHALL implement the FSM states IDLE, LOAD, CHECK and COMMIT.
REQ-013 SHALL behave as follows in IDLE: o__cfg_ready=0, o__cfg_busy=0; i__cfg_start moves the FSM to LOAD with word index 0.
REQ-014 SHALL behave as follows in LOAD: o__cfg_ready=1, o__cfg_busy=1; each handshake writes the shadow slot at the word index, then increments the index.
REQ-015 SHALL map frame words as follows: words 0..10 load cons_1..cons_11.
REQ-016 SHALL map word 11 (ctrl0) as follows: bits[6:0] sel_1..sel_7; [8:7] sel_8; [10:9] sel_9; [11] sel_10; [13:12] sel_11; [15:14] sel_12; [19:16] sel_13..sel_16; [21:20] sel_17; [23:22] sel_18; [24] sel_19; [26:25] sel_20; [28:27] sel_21; [31:29] ignored.
REQ-017 SHALL map word 12 (ctrl1) as follows: [1:0] rel_op1; [3:2] rel_op2; [5:4] rel_op3; [9:6] arith_op1..arith_op4; [31:10] ignored.
REQ-018 SHALL, on the word-12 handshake, go to COMMIT, or to CHECK when the feature of REQ-027 is compiled in.
REQ-019 SHALL behave as follows in COMMIT (one cycle): copy shadow to active; assert o__cfg_done for exactly one cycle; return to IDLE. The new active values are visible the same cycle that o__cfg_done is 1.
REQ-020 SHALL hold the active outputs constant at all times except in COMMIT; a partially loaded frame never reaches the outputs.
REQ-021 SHALL handle i__cfg_start in LOAD or CHECK as follows: abort the frame, pulse o__cfg_err for one cycle, and restart at index 0. Any handshake on that cycle is discarded.
REQ-022 SHALL ignore i__cfg_start in COMMIT; the commit completes.
REQ-023 SHALL use a 4-bit word index that never exceeds 12.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, set the following: FSM=IDLE, index=0, all shadow and active registers=0, o__cfg_done=0, o__cfg_err=0, o__cfg_busy=0, o__cfg_ready=0.
REQ-025 SHALL give rst priority over every other input, including mid-frame and during COMMIT; no commit results.
REQ-026 SHALL keep the active outputs at 0 after reset until the first successful commit.

Configuration
REQ-027 SHALL compile in the checksum feature when macro NESTED_IFS_CFG_CHECKSUM_EN is defined: in CHECK, one further word (word 13) is accepted with o__cfg_ready=1.
REQ-028 SHALL, with the macro defined, go to COMMIT if word 13 equals the XOR of words 0..12; otherwise pulse o__cfg_err, return to IDLE, and leave the active registers unchanged.
REQ-029 SHALL, without the macro, never enter CHECK; a frame is 13 words, and no checksum logic or checksum register is present.

Structure
REQ-030 SHALL put the following in a shared package: typedefs int32_t, int2_t and bool; word-index constants; ctrl0/ctrl1 bit-position constants; the FSM state enum; and a packed config struct used by both the shadow and active registers.
REQ-031 SHALL instantiate one sub-module, nested_ifs_cfg_unpack: a combinational decoder from ctrl0/ctrl1 to the select/opcode fields.

Verification
REQ-032 SHALL cover full frame load: start, then words 0..12 with cons_k=k, ctrl0=0x1FFFFFFF, ctrl1=0x3FF, valid every cycle -> o__cfg_done 1 cycle after the word-12 handshake; o__cons_5=5; every sel at its maximum value; rel_op=3; arith_op=1.
REQ-033 SHALL cover valid gaps: the same frame with i__cfg_valid toggled 1/0 -> same result; outputs unchanged until o__cfg_done.
REQ-034 SHALL cover abort: i__cfg_start after word 6 of a second frame (cons=0xAA) -> o__cfg_err pulse; o__cons_1 still 1; a fresh full frame then commits.
REQ-035 SHALL cover reset mid-frame: rst asserted at word 9 -> all outputs 0, IDLE, no o__cfg_done.
REQ-036 SHALL cover the checksum, with the macro defined: a correct XOR word 13 -> commit; word 13 XOR 1 -> o__cfg_err, active outputs unchanged.
REQ-037 SHALL cover reserved bits: ctrl0[31:29]=7 and ctrl1[31:10] all ones -> decoded fields unaffected.
